// File: rtl/boot_loader.sv
// Boot loader: streams a little-endian byte image (header N, N words, `BOOT_CHECKSUM_EN trailer) into IMEM, then releases cpu_ena.
// Registered IMEM write one cycle after a word's 4th byte; rx_ready drops permanently in DONE/ERROR.
module boot_loader #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        imem_we,
  output logic [31:0] imem_waddr,
  output logic [31:0] imem_wdata,
  output logic        cpu_ena,
  output logic        boot_done,
  output logic        boot_error
);

  typedef enum logic [2:0] {
    HDR,
    DATA,
`ifdef BOOT_CHECKSUM_EN
    CSUM,
`endif
    DONE,
    ERROR
  } state_t;

  state_t      state;
  logic [1:0]  byte_idx;
  logic [23:0] wbuf;
  logic [31:0] nwords;
  logic [31:0] wcnt;
`ifdef BOOT_CHECKSUM_EN
  logic [31:0] xacc;
`endif

  logic        accept;
  logic        word_end;
  logic [31:0] word;
  logic [32:0] max_words;

  assign accept    = rx_valid & rx_ready;
  assign word_end  = accept && (byte_idx == 2'd3);
  assign word      = {rx_data, wbuf};
  assign max_words = 33'd1 << ADDR_WIDTH;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= HDR;
      byte_idx   <= 2'd0;
      wbuf       <= 24'd0;
      nwords     <= 32'd0;
      wcnt       <= 32'd0;
`ifdef BOOT_CHECKSUM_EN
      xacc       <= 32'd0;
`endif
      rx_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_waddr <= 32'd0;
      imem_wdata <= 32'd0;
      cpu_ena    <= 1'b0;
      boot_done  <= 1'b0;
      boot_error <= 1'b0;
    end else begin
      imem_we  <= 1'b0;
      rx_ready <= (state != DONE) && (state != ERROR);
      // Enable follows DONE by one edge so the final write pulse has already completed.
      cpu_ena  <= (state == DONE);

      if (accept) begin
        byte_idx <= byte_idx + 2'd1;
        case (byte_idx)
          2'd0:    wbuf[7:0]   <= rx_data;
          2'd1:    wbuf[15:8]  <= rx_data;
          2'd2:    wbuf[23:16] <= rx_data;
          default: ;
        endcase
      end

      if (word_end) begin
        case (state)
          HDR: begin
            nwords <= word;
            if ({1'b0, word} > max_words) begin
              state      <= ERROR;
              boot_error <= 1'b1;
              rx_ready   <= 1'b0;
            end else if (word == 32'd0) begin
`ifdef BOOT_CHECKSUM_EN
              state <= CSUM;
`else
              state     <= DONE;
              boot_done <= 1'b1;
              rx_ready  <= 1'b0;
`endif
            end else begin
              state <= DATA;
            end
          end
          DATA: begin
            imem_we    <= 1'b1;
            imem_waddr <= wcnt << 2;
            imem_wdata <= word;
            wcnt       <= wcnt + 32'd1;
`ifdef BOOT_CHECKSUM_EN
            xacc <= xacc ^ word;
            if (wcnt + 32'd1 == nwords) state <= CSUM;
`else
            if (wcnt + 32'd1 == nwords) begin
              state     <= DONE;
              boot_done <= 1'b1;
              rx_ready  <= 1'b0;
            end
`endif
          end
`ifdef BOOT_CHECKSUM_EN
          CSUM: begin
            rx_ready <= 1'b0;
            if (word == xacc) begin
              state     <= DONE;
              boot_done <= 1'b1;
            end else begin
              state      <= ERROR;
              boot_error <= 1'b1;
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: image loads, header bounds, checksum, gaps and mid-load reset.
module tb_boot_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        imem_we;
  logic [31:0] imem_waddr;
  logic [31:0] imem_wdata;
  logic        cpu_ena;
  logic        boot_done;
  logic        boot_error;

  always #5 clk = ~clk;

  boot_loader #(.ADDR_WIDTH(10)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .imem_we    (imem_we),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata),
    .cpu_ena    (cpu_ena),
    .boot_done  (boot_done),
    .boot_error (boot_error)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_we = -1;
  int ena_cyc = -1;
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  logic [31:0] exp_w[16];
  logic [31:0] xsum;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (imem_we) begin
      wr_addr.push_back(imem_waddr);
      wr_data.push_back(imem_wdata);
      last_we = cyc;
    end
    if (cpu_ena && ena_cyc < 0) ena_cyc = cyc;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    rx_valid = 1'b0;
    tick(gap);
    rx_valid = 1'b1;
    rx_data  = b;
    n = 0;
    while (!rx_ready && n < 50) begin
      tick(1);
      n++;
    end
    chk("accept_wait", 32'(rx_ready), 32'd1);
    tick(1);
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gapmax);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], $urandom_range(0, gapmax));
  endtask

  task automatic do_reset();
    reset    = 1'b0;
    rx_valid = 1'b0;
    tick(2);
    wr_addr.delete();
    wr_data.delete();
    last_we = -1;
    ena_cyc = -1;
    reset   = 1'b1;
    tick(1);
  endtask

  task automatic check_write(input int i, input logic [31:0] a, input logic [31:0] d);
    chk($sformatf("waddr[%0d]", i), (i < wr_addr.size()) ? wr_addr[i] : 32'hFFFF_FFFF, a);
    chk($sformatf("wdata[%0d]", i), (i < wr_data.size()) ? wr_data[i] : 32'hFFFF_FFFF, d);
  endtask

  initial begin
    // Reset state
    tick(3);
    chk("rst_rx_ready", 32'(rx_ready), 32'd0);
    chk("rst_we", 32'(imem_we), 32'd0);
    chk("rst_waddr", imem_waddr, 32'd0);
    chk("rst_wdata", imem_wdata, 32'd0);
    chk("rst_cpu_ena", 32'(cpu_ena), 32'd0);
    chk("rst_done", 32'(boot_done), 32'd0);
    chk("rst_error", 32'(boot_error), 32'd0);
    reset = 1'b1;
    chk("rdy_before_edge", 32'(rx_ready), 32'd0);
    tick(1);
    chk("rdy_after_edge", 32'(rx_ready), 32'd1);

    // Two-word image
    send_word(32'h0000_0002, 0);
    send_word(32'h1234_5678, 0);
    send_word(32'hDEAD_BEEF, 0);
`ifdef BOOT_CHECKSUM_EN
    send_word(32'hCC99_E897, 0);
`endif
    tick(3);
    chk("t1_count", 32'(wr_addr.size()), 32'd2);
    check_write(0, 32'h0, 32'h1234_5678);
    check_write(1, 32'h4, 32'hDEAD_BEEF);
`ifdef BOOT_CHECKSUM_EN
    chk("t1_ena_after_we", 32'(ena_cyc > last_we), 32'd1);
`else
    chk("t1_ena_timing", 32'(ena_cyc), 32'(last_we + 1));
`endif
    chk("t1_cpu_ena", 32'(cpu_ena), 32'd1);
    chk("t1_done", 32'(boot_done), 32'd1);
    chk("t1_error", 32'(boot_error), 32'd0);
    chk("t1_rx_ready", 32'(rx_ready), 32'd0);
    chk("t1_waddr_hold", imem_waddr, 32'h4);
    chk("t1_wdata_hold", imem_wdata, 32'hDEAD_BEEF);

    // Bytes offered after DONE are not consumed
    rx_valid = 1'b1;
    rx_data  = 8'h55;
    tick(5);
    rx_valid = 1'b0;
    chk("ign_rx_ready", 32'(rx_ready), 32'd0);
    chk("ign_count", 32'(wr_addr.size()), 32'd2);

    // Asynchronous reset drop of cpu_ena
    reset = 1'b0;
    #1;
    chk("async_cpu_ena", 32'(cpu_ena), 32'd0);
    chk("async_done", 32'(boot_done), 32'd0);
    chk("async_rx_ready", 32'(rx_ready), 32'd0);
    chk("async_waddr", imem_waddr, 32'd0);
    do_reset();

    // Header overflow: N = 1025
    send_word(32'h0000_0401, 0);
    chk("ovf_error_edge", 32'(boot_error), 32'd1);
    tick(3);
    chk("ovf_count", 32'(wr_addr.size()), 32'd0);
    chk("ovf_cpu_ena", 32'(cpu_ena), 32'd0);
    chk("ovf_rx_ready", 32'(rx_ready), 32'd0);
    chk("ovf_done", 32'(boot_done), 32'd0);

    // N = 1024 is accepted
    do_reset();
    send_word(32'h0000_0400, 0);
    chk("max_error", 32'(boot_error), 32'd0);
    chk("max_rx_ready", 32'(rx_ready), 32'd1);

    // Empty image
    do_reset();
    send_word(32'h0, 0);
`ifdef BOOT_CHECKSUM_EN
    chk("n0_not_done", 32'(boot_done), 32'd0);
    send_word(32'h0, 0);
    chk("n0_done", 32'(boot_done), 32'd1);
    tick(1);
    chk("n0_cpu_ena", 32'(cpu_ena), 32'd1);
`else
    chk("n0_done", 32'(boot_done), 32'd1);
    chk("n0_ena_low", 32'(cpu_ena), 32'd0);
    tick(1);
    chk("n0_ena_high", 32'(cpu_ena), 32'd1);
`endif
    chk("n0_count", 32'(wr_addr.size()), 32'd0);

`ifdef BOOT_CHECKSUM_EN
    // Checksum mismatch
    do_reset();
    send_word(32'h0000_0002, 0);
    send_word(32'h1234_5678, 0);
    send_word(32'hDEAD_BEEF, 0);
    send_word(32'h0000_0000, 0);
    chk("csf_error", 32'(boot_error), 32'd1);
    tick(3);
    chk("csf_cpu_ena", 32'(cpu_ena), 32'd0);
    chk("csf_done", 32'(boot_done), 32'd0);
    chk("csf_rx_ready", 32'(rx_ready), 32'd0);
    chk("csf_count", 32'(wr_addr.size()), 32'd2);
`endif

    // Gapped 16-word image
    do_reset();
    xsum = 32'h0;
    send_word(32'd16, 7);
    for (int k = 0; k < 16; k++) begin
      exp_w[k] = (32'hA500_0000 ^ (32'(k) * 32'h0001_0203)) + 32'(k);
      xsum ^= exp_w[k];
      send_word(exp_w[k], 7);
    end
`ifdef BOOT_CHECKSUM_EN
    send_word(xsum, 7);
`endif
    tick(3);
    chk("gap_count", 32'(wr_addr.size()), 32'd16);
    for (int k = 0; k < 16; k++) check_write(k, 32'(4 * k), exp_w[k]);
    chk("gap_done", 32'(boot_done), 32'd1);
    chk("gap_cpu_ena", 32'(cpu_ena), 32'd1);

    // Reset during word 3, then reload a single word
    do_reset();
    send_word(32'd5, 0);
    for (int k = 0; k < 3; k++) send_word(exp_w[k], 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    tick(2);
    reset = 1'b0;
    #1;
    chk("mid_cpu_ena", 32'(cpu_ena), 32'd0);
    chk("mid_rx_ready", 32'(rx_ready), 32'd0);
    chk("mid_we", 32'(imem_we), 32'd0);
    chk("mid_count", 32'(wr_addr.size()), 32'd3);
    do_reset();
    send_word(32'd1, 0);
    send_word(32'hCAFE_F00D, 0);
`ifdef BOOT_CHECKSUM_EN
    send_word(32'hCAFE_F00D, 0);
`endif
    tick(3);
    chk("reload_count", 32'(wr_addr.size()), 32'd1);
    check_write(0, 32'h0, 32'hCAFE_F00D);
    chk("reload_done", 32'(boot_done), 32'd1);
    chk("reload_cpu_ena", 32'(cpu_ena), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
